ctxt_byte_serializer: RTL and testbench



---
 rtl/rst_cipher_pkg.sv | 17 +
 rtl/pair_fifo.sv | 55 +++++
 rtl/ctxt_byte_serializer.sv | 127 ++++++++++++
 tb/tb_ctxt_byte_serializer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/rst_cipher_pkg.sv
// rtl/rst_cipher_pkg.sv - shared types and constants for the RST cipher datapath
package rst_cipher_pkg;

    typedef enum logic [1:0] {
        SER_IDLE = 2'd0,
        SER_HI   = 2'd1,
        SER_LO   = 2'd2
    } ser_state_t;

    localparam logic [7:0] MARKER_CHAR = 8'h23;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
    } ctxt_pair_t;

endpackage

// File: rtl/pair_fifo.sv
// rtl/pair_fifo.sv - single-clock FIFO with push/pop, full/empty and occupancy count
module pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ctxt_byte_serializer.sv
// rtl/ctxt_byte_serializer.sv - buffers ciphertext pairs and emits them as a byte stream; CTXT_SER_ERR_MARKER_EN adds "##" markers
module ctxt_byte_serializer
    import rst_cipher_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [15:0]                   ctxt_str,
    input  logic                          ctxt_ready,
    input  logic                          err_invalid_ptxt,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fifo_full,
    output logic                          overflow,
    input  logic                          ovf_clr
);

    ser_state_t state, state_next;
    ctxt_pair_t hold;
    ctxt_pair_t head;
    ctxt_pair_t push_data;
    logic       push_req;
    logic       pop;
    logic       fifo_empty;
    logic       drop;
    logic [7:0] byte_next;
    logic       valid_next;
    logic       last_next;

`ifdef CTXT_SER_ERR_MARKER_EN
    assign push_req  = ctxt_ready || err_invalid_ptxt;
    assign push_data = ctxt_ready ? ctxt_pair_t'(ctxt_str) : ctxt_pair_t'({MARKER_CHAR, MARKER_CHAR});
`else
    logic unused_err;
    assign unused_err = err_invalid_ptxt;
    assign push_req   = ctxt_ready;
    assign push_data  = ctxt_pair_t'(ctxt_str);
`endif

    assign drop = push_req && fifo_full && !pop;

    pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .wdata (push_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SER_IDLE;
            hold      <= '0;
            out_byte  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            out_byte  <= byte_next;
            out_valid <= valid_next;
            out_last  <= last_next;
            if (pop) hold <= head;
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        byte_next  = out_byte;
        valid_next = out_valid;
        last_next  = out_last;
        case (state)
            SER_IDLE: begin
                valid_next = 1'b0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SER_HI;
                    byte_next  = head.row;
                    valid_next = 1'b1;
                    last_next  = 1'b0;
                end
            end
            SER_HI: begin
                if (out_ready) begin
                    state_next = SER_LO;
                    byte_next  = hold.col;
                    last_next  = 1'b1;
                end
            end
            SER_LO: begin
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = SER_HI;
                        byte_next  = head.row;
                        last_next  = 1'b0;
                    end else begin
                        state_next = SER_IDLE;
                        valid_next = 1'b0;
                        last_next  = 1'b0;
                    end
                end
            end
            default: begin
                state_next = SER_IDLE;
                valid_next = 1'b0;
                last_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctxt_byte_serializer.sv
// tb/tb_ctxt_byte_serializer.sv - scoreboard bench for ctxt_byte_serializer
module tb_ctxt_byte_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] ctxt_str;
    logic        ctxt_ready;
    logic        err_invalid_ptxt;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [2:0]  fifo_count;
    logic        fifo_full;
    logic        overflow;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];

    ctxt_byte_serializer #(.FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ctxt_str         (ctxt_str),
        .ctxt_ready       (ctxt_ready),
        .err_invalid_ptxt (err_invalid_ptxt),
        .out_byte         (out_byte),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_last         (out_last),
        .fifo_count       (fifo_count),
        .fifo_full        (fifo_full),
        .overflow         (overflow),
        .ovf_clr          (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge, so a transfer seen here happens at the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) check("extra_byte", {23'd0, out_last, out_byte}, 32'h1ff);
            else check("stream_byte", {23'd0, out_last, out_byte}, {23'd0, sb.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pair(input logic [15:0] p);
        sb.push_back({1'b0, p[15:8]});
        sb.push_back({1'b1, p[7:0]});
    endtask

    task automatic push(input logic [15:0] p, input bit keep);
        ctxt_str   = p;
        ctxt_ready = 1'b1;
        if (keep) expect_pair(p);
        tick();
        ctxt_ready = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_done", {31'd0, (sb.size() == 0 && !out_valid)}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; ctxt_str = '0; ctxt_ready = 1'b0; err_invalid_ptxt = 1'b0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (2) tick();
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_byte", {24'd0, out_byte}, 0);
        check("rst_last", {31'd0, out_last}, 0);
        check("rst_count", {29'd0, fifo_count}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        rst_n = 1'b1;
        tick();

        // single pair, first-byte latency
        out_ready = 1'b1;
        push(16'h4142, 1'b1);
        check("single_lat0", {31'd0, out_valid}, 0);
        tick();
        check("single_valid", {31'd0, out_valid}, 1);
        check("single_hi", {23'd0, out_last, out_byte}, 32'h041);
        drain();
        check("single_count", {29'd0, fifo_count}, 0);

        // backpressure
        out_ready = 1'b0;
        push(16'h6162, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {22'd0, out_valid, out_last, out_byte}, 32'h261);
            tick();
        end
        drain();

        // overflow
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(16'h3031 + 16'(i) * 16'h0101, i < 5);
        check("ovf_count", {29'd0, fifo_count}, 4);
        check("ovf_full", {31'd0, fifo_full}, 1);
        check("ovf_flag", {31'd0, overflow}, 1);
        drain();
        check("ovf_sticky", {31'd0, overflow}, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, overflow}, 0);

        // simultaneous push and pop while full
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(16'h4041 + 16'(i) * 16'h0101, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sim_in_lo", {31'd0, out_last}, 1);
        out_ready = 1'b1;
        push(16'h7A7A, 1'b1);
        out_ready = 1'b0;
        check("sim_count", {29'd0, fifo_count}, 4);
        check("sim_full", {31'd0, fifo_full}, 1);
        check("sim_ovf", {31'd0, overflow}, 0);
        drain();

        // sustained drain: no bubble between pairs
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(16'h5051 + 16'(i) * 16'h0101, 1'b1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rate_valid", {31'd0, out_valid}, 1);
            tick();
        end
        check("rate_done", {31'd0, out_valid}, 0);
        drain();

        // reset mid-pair
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(16'h6061 + 16'(i) * 16'h0101, 1'b1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("mrst_valid", {31'd0, out_valid}, 0);
        check("mrst_byte", {24'd0, out_byte}, 0);
        check("mrst_count", {29'd0, fifo_count}, 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) tick();
        check("mrst_stale", {31'd0, out_valid}, 0);

        // error marker
        err_invalid_ptxt = 1'b1;
`ifdef CTXT_SER_ERR_MARKER_EN
        expect_pair(16'h2323);
`endif
        tick();
        err_invalid_ptxt = 1'b0;
        repeat (4) tick();
        drain();
        check("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
